// File: rtl/spram_arbiter_pkg.sv
// Shared types for the single-port RAM arbiter: owner FSM states and side encoding.
package spram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } owner_e;

  localparam logic SIDE_A = 1'b0;
  localparam logic SIDE_B = 1'b1;

endpackage

// File: rtl/spram_arbiter_if.sv
// Requester A/B, and RAM pin bundle, around the arbiter; slave = arbiter view, master = environment view.
interface spram_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) ();

  logic                  a_req;
  logic                  a_wr;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_din;
  logic                  a_gnt;
  logic                  a_rvalid;
  logic [DATA_WIDTH-1:0] a_dout;

  logic                  b_req;
  logic                  b_wr;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_din;
  logic                  b_gnt;
  logic                  b_rvalid;
  logic [DATA_WIDTH-1:0] b_dout;

  logic                  ram_wr;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_din;
  logic [DATA_WIDTH-1:0] ram_dout;

  modport slave (
    input  a_req, a_wr, a_addr, a_din,
    input  b_req, b_wr, b_addr, b_din,
    input  ram_dout,
    output a_gnt, a_rvalid, a_dout,
    output b_gnt, b_rvalid, b_dout,
    output ram_wr, ram_addr, ram_din
  );

  modport master (
    output a_req, a_wr, a_addr, a_din,
    output b_req, b_wr, b_addr, b_din,
    output ram_dout,
    input  a_gnt, a_rvalid, a_dout,
    input  b_gnt, b_rvalid, b_dout,
    input  ram_wr, ram_addr, ram_din
  );

endinterface

// File: rtl/spram_arbiter_rr_burst_arb2.sv
// Two-way round-robin arbiter with bounded bursts; combinational one-hot grant,
// owner/last/beat count registered. Grants are forced low while rst_n is asserted.
module rr_burst_arb2
  import spram_arb_pkg::*;
#(
  parameter int BURST_LEN = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  localparam int CW = $clog2(BURST_LEN + 1);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t BL = cnt_t'(BURST_LEN);

  owner_e state_q, state_d;
  logic   last_q, last_d;
  cnt_t   cnt_q, cnt_d;
  logic   own, oth, win, win_vld;
  logic [1:0] gnt_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= SIDE_B;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    gnt_c   = 2'b00;
    win     = SIDE_A;
    win_vld = 1'b0;
    own     = (state_q == OWN_B) ? SIDE_B : SIDE_A;
    oth     = ~own;

    if (state_q == IDLE) begin
      if (req[0] && req[1]) begin
        win_vld = 1'b1;
        win     = ~last_q;
      end else if (req[0]) begin
        win_vld = 1'b1;
        win     = SIDE_A;
      end else if (req[1]) begin
        win_vld = 1'b1;
        win     = SIDE_B;
      end
    end else begin
      if (req[own] && (cnt_q < BL)) begin
        win_vld = 1'b1;
        win     = own;
      end else if (req[oth]) begin
        win_vld = 1'b1;
        win     = oth;
      end else if (req[own]) begin
        win_vld = 1'b1;
        win     = own;
      end
    end

    if (win_vld) begin
      gnt_c[win] = 1'b1;
      state_d    = (win == SIDE_B) ? OWN_B : OWN_A;
      last_d     = win;
      // A side switch or an uncontested overrun restarts the burst at one beat.
      if ((state_q != IDLE) && (win != own)) begin
        cnt_d = cnt_t'(1);
      end else if (cnt_q < BL) begin
        cnt_d = cnt_q + cnt_t'(1);
      end else begin
        cnt_d = cnt_t'(1);
      end
    end else begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  assign gnt = gnt_c & {2{rst_n}};

endmodule

// File: rtl/spram_arbiter.sv
// Shares one single-port RAM between requesters A and B; grant is same-cycle,
// read data returns one cycle after the read grant to the requester that issued it.
module spram_arbiter
  import spram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int BURST_LEN  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  spram_arbiter_if.slave   bus
);

  logic [1:0]            req;
  logic [1:0]            gnt;
  logic                  mux_wr;
  logic [ADDR_WIDTH-1:0] mux_addr;
  logic [DATA_WIDTH-1:0] mux_din;
  logic                  a_rvalid_q, b_rvalid_q;

  assign req = {bus.b_req, bus.a_req};

  rr_burst_arb2 #(
    .BURST_LEN (BURST_LEN)
  ) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt   (gnt)
  );

  assign bus.a_gnt = gnt[SIDE_A];
  assign bus.b_gnt = gnt[SIDE_B];

  always_comb begin
    mux_wr   = 1'b0;
    mux_addr = '0;
    mux_din  = '0;
    if (gnt[SIDE_A]) begin
      mux_wr   = bus.a_wr;
      mux_addr = bus.a_addr;
      mux_din  = bus.a_din;
    end else if (gnt[SIDE_B]) begin
      mux_wr   = bus.b_wr;
      mux_addr = bus.b_addr;
      mux_din  = bus.b_din;
    end
  end

  assign bus.ram_wr   = mux_wr;
  assign bus.ram_addr = mux_addr;
  assign bus.ram_din  = mux_din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      a_rvalid_q <= gnt[SIDE_A] & ~bus.a_wr;
      b_rvalid_q <= gnt[SIDE_B] & ~bus.b_wr;
    end
  end

  assign bus.a_rvalid = a_rvalid_q;
  assign bus.b_rvalid = b_rvalid_q;
  assign bus.a_dout   = bus.ram_dout;
  assign bus.b_dout   = bus.ram_dout;

endmodule

// File: tb/tb_spram_arbiter.sv
// Bench for spram_arbiter: RAM model, directed scenarios and random traffic checked
// every cycle against a grant-history reference model.
module tb_spram_arbiter;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int BL = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spram_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  spram_arbiter #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .BURST_LEN  (BL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DW-1:0] mem [2**AW];
  always @(posedge clk) begin
    if (bus.ram_wr) mem[bus.ram_addr] <= bus.ram_din;
    bus.ram_dout <= mem[bus.ram_addr];
  end

  int total = 0;
  int bad   = 0;

  // Reference state: side granted in the previous cycle (-1 = none), its run length, last winner.
  int prev      = -1;
  int run       = 0;
  int last_side = 1;
  int ref_mem [2**AW];
  bit pend_a, pend_b;
  int pend_a_dat, pend_b_dat;

  logic obs_ga, obs_gb, obs_rva, obs_rvb, obs_wr;
  logic [AW-1:0] obs_addr;
  logic [DW-1:0] obs_adout, obs_bdout;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int model_winner(input bit ra, input bit rb);
    int w;
    bit r [2];
    w = -1;
    r[0] = ra;
    r[1] = rb;
    if (prev >= 0) begin
      if (r[prev] && run < BL) w = prev;
      else if (r[1-prev])      w = 1 - prev;
      else if (r[prev])        w = prev;
    end else begin
      if (ra && rb) w = 1 - last_side;
      else if (ra)  w = 0;
      else if (rb)  w = 1;
    end
    return w;
  endfunction

  task automatic step();
    int w;
    int e_wr, e_addr, e_din;
    @(negedge clk);
    w = rst_n ? model_winner(bus.a_req, bus.b_req) : -1;
    e_wr = 0; e_addr = 0; e_din = 0;
    if (w == 0) begin e_wr = bus.a_wr; e_addr = bus.a_addr; e_din = bus.a_din; end
    if (w == 1) begin e_wr = bus.b_wr; e_addr = bus.b_addr; e_din = bus.b_din; end

    chk("a_gnt", bus.a_gnt, (w == 0) ? 1 : 0);
    chk("b_gnt", bus.b_gnt, (w == 1) ? 1 : 0);
    chk("ram_wr", bus.ram_wr, e_wr);
    chk("ram_addr", bus.ram_addr, e_addr);
    chk("ram_din", bus.ram_din, e_din);
    chk("a_rvalid", bus.a_rvalid, (pend_a && rst_n) ? 1 : 0);
    chk("b_rvalid", bus.b_rvalid, (pend_b && rst_n) ? 1 : 0);
    if (pend_a && rst_n) chk("a_dout", bus.a_dout, pend_a_dat);
    if (pend_b && rst_n) chk("b_dout", bus.b_dout, pend_b_dat);

    obs_ga = bus.a_gnt;   obs_gb = bus.b_gnt;
    obs_rva = bus.a_rvalid; obs_rvb = bus.b_rvalid;
    obs_wr = bus.ram_wr;  obs_addr = bus.ram_addr;
    obs_adout = bus.a_dout; obs_bdout = bus.b_dout;

    pend_a = (w == 0) && !bus.a_wr;
    pend_b = (w == 1) && !bus.b_wr;
    pend_a_dat = ref_mem[bus.a_addr];
    pend_b_dat = ref_mem[bus.b_addr];
    if (w >= 0 && e_wr != 0) ref_mem[e_addr] = e_din;

    if (w >= 0) begin
      run = (w == prev && run < BL) ? run + 1 : 1;
      prev = w;
      last_side = w;
    end else begin
      prev = -1;
      run = 0;
    end
    if (!rst_n) begin
      prev = -1; run = 0; last_side = 1; pend_a = 0; pend_b = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input bit rq, input bit wr, input int addr, input int din);
    bus.a_req = rq; bus.a_wr = wr; bus.a_addr = AW'(addr); bus.a_din = DW'(din);
  endtask

  task automatic drive_b(input bit rq, input bit wr, input int addr, input int din);
    bus.b_req = rq; bus.b_wr = wr; bus.b_addr = AW'(addr); bus.b_din = DW'(din);
  endtask

  initial begin
    int ia, ib, ng;
    string exp_seq;
    byte gseq [16];

    foreach (ref_mem[i]) ref_mem[i] = 0;
    foreach (mem[i]) mem[i] = '0;
    pend_a = 0; pend_b = 0;
    rst_n = 1'b0;
    drive_a(0, 0, 0, 0);
    drive_b(0, 0, 0, 0);
    #1;

    // Reset, then idle.
    step();
    step();
    chk("rst_ram_addr", obs_addr, 0);
    rst_n = 1'b1;
    step();
    step();
    chk("idle_a_gnt", obs_ga, 0);
    chk("idle_b_gnt", obs_gb, 0);
    chk("idle_rvalid", obs_rva | obs_rvb, 0);
    chk("idle_ram_wr", obs_wr, 0);

    // Contention with both sides writing continuously.
    ia = 0; ib = 0; ng = 0;
    for (int t = 0; t < 40 && (ia < 8 || ib < 8); t++) begin
      drive_a(ia < 8, 1, ia, 100 + ia);
      drive_b(ib < 8, 1, 8 + ib, 208 + ib);
      step();
      if (obs_ga) begin ia++; if (ng < 16) gseq[ng] = "A"; ng++; end
      if (obs_gb) begin ib++; if (ng < 16) gseq[ng] = "B"; ng++; end
    end
    chk("contention_done", ia + ib, 16);
    exp_seq = "AAAABBBBAAAABBBB";
    for (int i = 0; i < 16; i++) chk("grant_order", gseq[i], exp_seq[i]);
    drive_a(0, 0, 0, 0);
    drive_b(0, 0, 0, 0);
    step();

    // Pipelined readback of all 16 words by A.
    for (int k = 0; k <= 16; k++) begin
      drive_a(k < 16, 0, k % 16, 0);
      step();
      if (k > 0) begin
        chk("readback_vld", obs_rva, 1);
        chk("readback_dat", obs_adout, (k - 1 < 8) ? 100 + k - 1 : 200 + k - 1);
      end
    end
    drive_a(0, 0, 0, 0);
    step();

    // A write then read of the same address.
    drive_a(1, 1, 3, 12); step(); chk("wr12_gnt", obs_ga, 1);
    drive_a(1, 0, 3, 0);  step(); chk("rd3_gnt", obs_ga, 1);
    drive_a(0, 0, 0, 0);  step();
    chk("rd3_vld", obs_rva, 1);
    chk("rd3_dat", obs_adout, 12);
    chk("rd3_b_vld", obs_rvb, 0);

    // Interleaved A read and B write.
    drive_a(1, 1, 5, 7);  step();
    drive_a(1, 0, 5, 0);  step();
    drive_a(0, 0, 0, 0);
    drive_b(1, 1, 7, 22); step();
    chk("mix_a_vld", obs_rva, 1);
    chk("mix_a_dat", obs_adout, 7);
    chk("mix_b_gnt", obs_gb, 1);
    drive_b(1, 0, 7, 0);  step();
    drive_b(0, 0, 0, 0);  step();
    chk("mix_b_vld", obs_rvb, 1);
    chk("mix_b_a_vld", obs_rva, 0);
    chk("mix_b_dat", obs_bdout, 22);

    // Early release: A owns for two beats, then hands over with no bubble.
    drive_a(1, 1, 1, 50); step(); chk("er_a1", obs_ga, 1);
    drive_a(1, 1, 2, 51); step(); chk("er_a2", obs_ga, 1);
    drive_a(0, 0, 0, 0);
    drive_b(1, 0, 0, 0);  step();
    chk("er_b_same_cycle", obs_gb, 1);
    drive_b(0, 0, 0, 0);  step();

    // Reset right after a read grant drops the read.
    drive_a(1, 0, 4, 0); step(); chk("rr_a_gnt", obs_ga, 1);
    rst_n = 1'b0;
    drive_a(1, 1, 6, 60);
    drive_b(1, 1, 9, 90);
    step();
    chk("rr_no_rvalid", obs_rva, 0);
    chk("rr_gnt_in_reset", obs_ga | obs_gb, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("rr_first_a", obs_ga, 1);
    chk("rr_first_not_b", obs_gb, 0);
    drive_a(0, 0, 0, 0);
    step();
    chk("rr_then_b", obs_gb, 1);
    chk("rr_late_rvalid", obs_rva, 0);
    drive_b(0, 0, 0, 0);
    step();

    // Random traffic, holding each request until granted, with rare reset pulses.
    for (int c = 0; c < 3000; c++) begin
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
      if (!bus.a_req || obs_ga)
        drive_a($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 15), $urandom_range(0, 255));
      if (!bus.b_req || obs_gb)
        drive_b($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 15), $urandom_range(0, 255));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
